// File: rtl/scoreboard_pkg.sv
// scoreboard_pkg: character codes, overlay geometry and game-state types shared by the scoreboard blocks
package scoreboard_pkg;
    localparam logic [6:0] CH_0 = 7'h30, CH_H = 7'h48, CH_A = 7'h41, CH_B = 7'h42;
    localparam logic [6:0] CH_S = 7'h53, CH_O = 7'h4F, CH_I = 7'h49, CH_SP = 7'h20;
    localparam int FIELD_CELLS = 16;
    localparam int CELL_W = 8;
    localparam int GLYPH_H = 16;
    localparam logic [1:0] BALL_MAX = 2'd3, STRIKE_MAX = 2'd2, OUT_MAX = 2'd2;
    localparam logic [3:0] INNING_CAP = 4'd9;

    typedef struct packed {
        logic [7:0] home;
        logic [7:0] away;
        logic [1:0] balls;
        logic [1:0] strikes;
        logic [1:0] outs;
        logic [3:0] inning;
    } disp_t;

    typedef struct packed {
        disp_t d;
        logic  half;
        logic  over;
    } game_t;

    localparam game_t GAME_RST = '{d: '{home: 8'h00, away: 8'h00, balls: 2'd0, strikes: 2'd0,
                                        outs: 2'd0, inning: 4'd1}, half: 1'b0, over: 1'b0};

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [3:0] lo, hi;
        lo = (v[3:0] == 4'd9) ? 4'd0 : v[3:0] + 4'd1;
        hi = (v[3:0] != 4'd9) ? v[7:4] : (v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1;
        return {hi, lo};
    endfunction

    function automatic logic [6:0] digit(input logic [3:0] v);
        return CH_0 + {3'd0, v};
    endfunction
endpackage

// File: rtl/scoreboard_if.sv
// scoreboard_if: game events, VGA timing, ROM port and status outputs of the scoreboard overlay
interface scoreboard_if;
    logic        frame_start, video_on;
    logic [9:0]  pixel_x, pixel_y;
    logic        ev_ball, ev_strike, ev_out, ev_run, ev_new_game;
    logic [10:0] rom_addr;
    logic [7:0]  rom_data;
    logic        text_on, half, game_over;

    modport master (output frame_start, video_on, pixel_x, pixel_y, ev_ball, ev_strike, ev_out,
                    ev_run, ev_new_game, rom_data, input rom_addr, text_on, half, game_over);
    modport slave (input frame_start, video_on, pixel_x, pixel_y, ev_ball, ev_strike, ev_out,
                   ev_run, ev_new_game, rom_data, output rom_addr, text_on, half, game_over);
endinterface

// File: rtl/scoreboard_state.sv
// scoreboard_state: prioritised event handling, count/run/inning state and the per-frame display snapshot
module scoreboard_state
    import scoreboard_pkg::*;
#(
    parameter logic [3:0] LAST_INNING = 4'd9
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  frame_start_i,
    input  logic  ev_ball_i,
    input  logic  ev_strike_i,
    input  logic  ev_out_i,
    input  logic  ev_run_i,
    input  logic  ev_new_game_i,
    output disp_t snap_o,
    output logic  half_o,
    output logic  game_over_o
);
    game_t g_q, g_d;
    disp_t snap_q;
    logic  is_out;

    always_comb begin
        g_d = g_q;
        is_out = 1'b0;
        if (ev_new_game_i) begin
            g_d = GAME_RST;
        end else if (!g_q.over) begin
            // runs credit the side batting before any half change this cycle
            if (ev_run_i && g_q.half) g_d.d.home = bcd_inc(g_q.d.home);
            if (ev_run_i && !g_q.half) g_d.d.away = bcd_inc(g_q.d.away);
            is_out = ev_out_i || (ev_strike_i && g_q.d.strikes == STRIKE_MAX);
            if (is_out) begin
                g_d.d.balls = 2'd0;
                g_d.d.strikes = 2'd0;
                g_d.d.outs = (g_q.d.outs < OUT_MAX) ? g_q.d.outs + 2'd1 : 2'd0;
                if (g_q.d.outs == OUT_MAX && g_q.half && g_q.d.inning == LAST_INNING) begin
                    g_d.over = 1'b1;
                end else if (g_q.d.outs == OUT_MAX) begin
                    g_d.half = ~g_q.half;
                    if (g_q.half)
                        g_d.d.inning = (g_q.d.inning < INNING_CAP) ? g_q.d.inning + 4'd1 : INNING_CAP;
                end
            end else if (ev_strike_i) begin
                g_d.d.strikes = g_q.d.strikes + 2'd1;
            end else if (ev_ball_i) begin
                g_d.d.balls = (g_q.d.balls == BALL_MAX) ? 2'd0 : g_q.d.balls + 2'd1;
                g_d.d.strikes = (g_q.d.balls == BALL_MAX) ? 2'd0 : g_q.d.strikes;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            g_q <= GAME_RST;
            snap_q <= GAME_RST.d;
        end else begin
            g_q <= g_d;
            if (frame_start_i) snap_q <= g_q.d;
        end
    end

    assign snap_o = snap_q;
    assign half_o = g_q.half;
    assign game_over_o = g_q.over;
endmodule

// File: rtl/scoreboard_ctrl.sv
// scoreboard_ctrl: maps the raster position to a character ROM address and renders the 3-clock text pipeline
module scoreboard_ctrl
    import scoreboard_pkg::*;
#(
    parameter logic [9:0] TX          = 10'd64,
    parameter logic [9:0] TY          = 10'd32,
    parameter logic [3:0] LAST_INNING = 4'd9
) (
    input logic         clk,
    input logic         reset,
    scoreboard_if.slave bus
);
    disp_t       snap;
    logic        in_text, text_on_d, text_on_q, in1_q, in2_q;
    logic [6:0]  dx, code;
    logic [3:0]  dy, col;
    logic [2:0]  bit1_q, bit2_q;
    logic [10:0] rom_addr_d, rom_addr_q;

    scoreboard_state #(.LAST_INNING(LAST_INNING)) u_state (
        .clk          (clk),
        .reset        (reset),
        .frame_start_i(bus.frame_start),
        .ev_ball_i    (bus.ev_ball),
        .ev_strike_i  (bus.ev_strike),
        .ev_out_i     (bus.ev_out),
        .ev_run_i     (bus.ev_run),
        .ev_new_game_i(bus.ev_new_game),
        .snap_o       (snap),
        .half_o       (bus.half),
        .game_over_o  (bus.game_over)
    );

    always_comb begin
        dx = 7'(bus.pixel_x - TX);
        dy = 4'(bus.pixel_y - TY);
        col = dx[6:3];
        in_text = bus.video_on && bus.pixel_x >= TX && bus.pixel_x < TX + 10'(FIELD_CELLS * CELL_W)
                  && bus.pixel_y >= TY && bus.pixel_y < TY + 10'(GLYPH_H);
        rom_addr_d = in_text ? {code, dy} : {CH_SP, 4'd0};
        text_on_d = in2_q & bus.rom_data[3'd7 - bit2_q];
    end

    // cell layout: "Hhh Aaa BbSsOoIi"
    always_comb begin
        code = CH_SP;
        case (col)
            4'd0:    code = CH_H;
            4'd1:    code = digit(snap.home[7:4]);
            4'd2:    code = digit(snap.home[3:0]);
            4'd4:    code = CH_A;
            4'd5:    code = digit(snap.away[7:4]);
            4'd6:    code = digit(snap.away[3:0]);
            4'd8:    code = CH_B;
            4'd9:    code = digit({2'd0, snap.balls});
            4'd10:   code = CH_S;
            4'd11:   code = digit({2'd0, snap.strikes});
            4'd12:   code = CH_O;
            4'd13:   code = digit({2'd0, snap.outs});
            4'd14:   code = CH_I;
            4'd15:   code = digit(snap.inning);
            default: code = CH_SP;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rom_addr_q <= '0;
            in1_q <= 1'b0;
            in2_q <= 1'b0;
            bit1_q <= 3'd0;
            bit2_q <= 3'd0;
            text_on_q <= 1'b0;
        end else begin
            rom_addr_q <= rom_addr_d;
            in1_q <= in_text;
            bit1_q <= dx[2:0];
            in2_q <= in1_q;
            bit2_q <= bit1_q;
            text_on_q <= text_on_d;
        end
    end

    assign bus.rom_addr = rom_addr_q;
    assign bus.text_on = text_on_q;
endmodule

// File: tb/tb_scoreboard_ctrl.sv
// tb_scoreboard_ctrl: vector table of event steps checked through the rendered overlay, plus corner sequences
module tb_scoreboard_ctrl;
    localparam logic [9:0] TX = 10'd64, TY = 10'd32;
    localparam logic [4:0] NEW = 5'b10000, OUT = 5'b01000, STR = 5'b00100, BALL = 5'b00010, RUN = 5'b00001;

    typedef struct packed {
        logic [4:0]   ev;
        logic [127:0] line;
        logic         half;
    } vec_t;
    typedef struct {
        int          due;
        logic [10:0] val;
    } exp_t;

    logic clk = 1'b0, reset = 1'b1;
    int   cyc = 0, n_vec = 0, n_bad = 0;
    exp_t aq[$], tq[$];
    vec_t tbl[20];

    scoreboard_if sb ();
    scoreboard_ctrl #(.TX(TX), .TY(TY), .LAST_INNING(4'd9)) dut (.clk(clk), .reset(reset), .bus(sb));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] glyph(input logic [10:0] a);
        return a[7:0] ^ {a[3:0], a[10:7]};
    endfunction

    always @(posedge clk) sb.rom_data <= glyph(sb.rom_addr);

    function automatic void check(input string nm, input logic [10:0] act, input logic [10:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        while (aq.size() > 0 && aq[0].due <= cyc) begin
            e = aq.pop_front();
            check("rom_addr", sb.rom_addr, e.val);
        end
        while (tq.size() > 0 && tq[0].due <= cyc) begin
            e = tq.pop_front();
            check("text_on", sb.text_on, e.val);
        end
    end

    task automatic step(input logic [4:0] ev, input logic fs, input logic vo, input logic [9:0] x,
                        input logic [9:0] y, input logic chk, input logic [10:0] ea, input logic et);
        {sb.ev_new_game, sb.ev_out, sb.ev_strike, sb.ev_ball, sb.ev_run} = ev;
        sb.frame_start = fs;
        sb.video_on = vo;
        sb.pixel_x = x;
        sb.pixel_y = y;
        if (chk) begin
            aq.push_back('{cyc + 1, ea});
            tq.push_back('{cyc + 3, {10'd0, et}});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [4:0] ev);
        step(ev, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 11'd0, 1'b0);
    endtask

    task automatic frame();
        step(5'd0, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 11'd0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) pulse(5'd0);
    endtask

    task automatic probe(input logic [9:0] x, input logic [9:0] y, input logic vo, input logic [10:0] ea);
        logic [7:0] g;
        logic [2:0] b;
        g = glyph(ea);
        b = x[2:0];
        step(5'd0, 1'b0, vo, x, y, 1'b1, ea, (ea == 11'h200) ? 1'b0 : g[3'd7 - b]);
    endtask

    task automatic check_line(input logic [127:0] line, input int seed);
        logic [3:0]  r;
        logic [2:0]  b;
        logic [10:0] a;
        for (int c = 0; c < 16; c++) begin
            r = 4'(c + seed);
            b = 3'(c * 3 + seed);
            a = {line[8 * (15 - c) +: 7], r};
            probe(TX + 10'(8 * c) + 10'(b), TY + 10'(r), 1'b1, a);
        end
        idle(3);
    endtask

    initial begin
        tbl[0]  = '{5'd0, "H00 A00 B0S0O0I1", 1'b0};
        tbl[1]  = '{BALL, "H00 A00 B1S0O0I1", 1'b0};
        tbl[2]  = '{BALL, "H00 A00 B2S0O0I1", 1'b0};
        tbl[3]  = '{BALL, "H00 A00 B3S0O0I1", 1'b0};
        tbl[4]  = '{BALL, "H00 A00 B0S0O0I1", 1'b0};
        tbl[5]  = '{STR,  "H00 A00 B0S1O0I1", 1'b0};
        tbl[6]  = '{BALL, "H00 A00 B1S1O0I1", 1'b0};
        tbl[7]  = '{STR,  "H00 A00 B1S2O0I1", 1'b0};
        tbl[8]  = '{STR,  "H00 A00 B0S0O1I1", 1'b0};
        tbl[9]  = '{STR,  "H00 A00 B0S1O1I1", 1'b0};
        tbl[10] = '{STR,  "H00 A00 B0S2O1I1", 1'b0};
        tbl[11] = '{STR,  "H00 A00 B0S0O2I1", 1'b0};
        tbl[12] = '{RUN,  "H00 A01 B0S0O2I1", 1'b0};
        tbl[13] = '{OUT | RUN, "H00 A02 B0S0O0I1", 1'b1};
        tbl[14] = '{RUN,  "H01 A02 B0S0O0I1", 1'b1};
        tbl[15] = '{OUT | STR | BALL, "H01 A02 B0S0O1I1", 1'b1};
        tbl[16] = '{BALL, "H01 A02 B1S0O1I1", 1'b1};
        tbl[17] = '{OUT,  "H01 A02 B0S0O2I1", 1'b1};
        tbl[18] = '{OUT,  "H01 A02 B0S0O0I2", 1'b0};
        tbl[19] = '{NEW | OUT | RUN | BALL, "H00 A00 B0S0O0I1", 1'b0};
        {sb.ev_new_game, sb.ev_out, sb.ev_strike, sb.ev_ball, sb.ev_run} = 5'd0;
        sb.frame_start = 1'b0;
        sb.video_on = 1'b0;
        sb.pixel_x = 10'd0;
        sb.pixel_y = 10'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset rom_addr", sb.rom_addr, 11'd0);
        check("reset text_on", 11'(sb.text_on), 11'd0);
        check("reset half", 11'(sb.half), 11'd0);
        check("reset game_over", 11'(sb.game_over), 11'd0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            pulse(tbl[i].ev);
            frame();
            check("half", 11'(sb.half), 11'(tbl[i].half));
            check("game_over", 11'(sb.game_over), 11'd0);
            check_line(tbl[i].line, i);
        end
        // BCD carry and wrap on the away counter
        repeat (9) pulse(RUN);
        frame();
        check_line("H00 A09 B0S0O0I1", 1);
        pulse(RUN);
        frame();
        check_line("H00 A10 B0S0O0I1", 2);
        repeat (89) pulse(RUN);
        frame();
        check_line("H00 A99 B0S0O0I1", 3);
        pulse(RUN);
        frame();
        check_line("H00 A00 B0S0O0I1", 4);
        // a run landing on the frame_start cycle shows only after the next frame_start
        step(RUN, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 11'd0, 1'b0);
        check_line("H00 A00 B0S0O0I1", 5);
        frame();
        check_line("H00 A01 B0S0O0I1", 6);
        // play to two outs in the bottom of the ninth, then end the game
        pulse(NEW);
        repeat (53) pulse(OUT);
        frame();
        check("half bot9", 11'(sb.half), 11'd1);
        check("game_over bot9", 11'(sb.game_over), 11'd0);
        check_line("H00 A00 B0S0O2I9", 7);
        pulse(OUT);
        check("game_over set", 11'(sb.game_over), 11'd1);
        check("half hold", 11'(sb.half), 11'd1);
        pulse(BALL);
        pulse(RUN);
        pulse(STR);
        frame();
        check_line("H00 A00 B0S0O0I9", 8);
        check("game_over hold", 11'(sb.game_over), 11'd1);
        pulse(NEW);
        check("new_game over", 11'(sb.game_over), 11'd0);
        check("new_game half", 11'(sb.half), 11'd0);
        check_line("H00 A00 B0S0O0I9", 9);
        frame();
        check_line("H00 A00 B0S0O0I1", 10);
        // field boundaries and blanking
        probe(TX - 10'd1, TY, 1'b1, 11'h200);
        probe(TX + 10'd128, TY, 1'b1, 11'h200);
        probe(TX, TY - 10'd1, 1'b1, 11'h200);
        probe(TX, TY + 10'd16, 1'b1, 11'h200);
        probe(TX + 10'd127, TY + 10'd15, 1'b0, 11'h200);
        probe(TX + 10'd127, TY + 10'd15, 1'b1, {7'h31, 4'hF});
        probe(TX, TY, 1'b1, {7'h48, 4'h0});
        idle(3);
        // hold a lit pixel, then reset in the middle of the line
        repeat (4) probe(TX, TY + 10'd5, 1'b1, {7'h48, 4'h5});
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("lit before reset", 11'(sb.text_on), 11'd1);
        reset = 1'b1;
        #1;
        check("midline reset text_on", 11'(sb.text_on), 11'd0);
        check("midline reset rom_addr", sb.rom_addr, 11'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.video_on = 1'b0;
        idle(4);
        check("scoreboard drained", 11'(aq.size() + tq.size()), 11'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/scoreboard_ctrl.md
Name: scoreboard_ctrl

Overview:
- Owns the baseball game state: runs, balls, strikes, outs, inning and half-inning.
- Sequences the 8x16 ASCII character ROM to draw a one-line, 16-character scoreboard overlay on the VGA raster.
- Sits between the game logic (event pulses), the VGA timing generator (pixel_x/pixel_y/video_on/frame_start) and one ASCII ROM instance.
- The top level ties the ROM's offset and num inputs to 0.

Parameters:
- TX, 10'd64, left pixel column of the text field (multiple of 8)
- TY, 10'd32, top pixel row of the text field
- LAST_INNING, 4'd9, inning whose bottom half's third out ends the game

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse at start of vertical blank
- video_on  in  1  visible-area flag for the current pixel
- pixel_x  in  10  current pixel column
- pixel_y  in  10  current pixel row
- ev_ball, ev_strike, ev_out, ev_run, ev_new_game  in  1 each  one-cycle event pulses
- rom_addr  out  11  {ascii[6:0], row[3:0]} to the ROM addr input
- rom_data  in  8  ROM glyph row; valid one cycle after rom_addr is registered into the ROM
- text_on  out  1  overlay pixel lit
- half  out  1  0 = top (away bats), 1 = bottom (home bats)
- game_over  out  1  game finished flag

Behaviour:
- Interface: one clock `clk`; reset `reset` is asynchronous and active-high.
- Reset values: runs_home = runs_away = 8'h00 (2-digit BCD); balls = 0; strikes = 0; outs = 0; inning = 1; half = 0; game_over = 0; display snapshot equals these values; rom_addr = 0; text_on = 0; all pipeline flags = 0.
- Events are evaluated every clk. Priority: ev_new_game > ev_out > ev_strike > ev_ball. Only the highest-priority of these three count events acts per cycle. ev_run is applied independently in the same cycle.
- ev_ball:
  - balls < 3: balls+1.
  - balls == 3 (walk): balls = 0, strikes = 0.
- ev_strike:
  - strikes < 2: strikes+1.
  - strikes == 2: processed exactly as ev_out.
- Out processing:
  - balls = 0, strikes = 0.
  - outs < 2: outs+1.
  - outs == 2: outs = 0 and half toggles. Bottom→top increments inning, capped at 9.
  - Third out in the bottom of LAST_INNING: game_over = 1; inning and half hold.
- ev_run: batting team's BCD counter +1 (away if half = 0, home if half = 1). Units digit 9→0 with carry; 99→00 wraps. If the same cycle's out changes half, the run credits the pre-change batting team.
- game_over = 1: all events except ev_new_game are ignored.
- ev_new_game: restores all reset values except the display snapshot. The snapshot updates at the next frame_start.
- Display snapshot: all displayed fields copy from live state only on a frame_start cycle. When an event and frame_start coincide, the snapshot captures the pre-event value (no tearing).
- Layout, 16 cells of 8 px: "H" h1 h0 " " "A" a1 a0 " " "B" b "S" s "O" o "I" i.
  - Digits map to 8'h30 + value.
  - Letters: H = 48, A = 41, B = 42, S = 53, O = 4F, I = 49, space = 20.
- Render pipeline, cycle N = pixel presented:
  - in_text = video_on & TX <= x < TX+128 & TY <= y < TY+16.
  - col = (x-TX)[6:3]; row = (y-TY)[3:0].
  - N+1: rom_addr registered = {code(col), row}, or 11'h200 (space) when not in_text. Also in_text_d1 and bit_d1 = x[2:0].
  - N+2: ROM data valid; delayed in_text_d2 and bit_d2.
  - N+3: text_on = in_text_d2 & rom_data[7 - bit_d2].
  - Fixed latency is 3 clocks; the top delays video colour by 3.
- Reset asserted mid-line forces text_on = 0 and clears the pipeline immediately.

Decomposition:
- Package scoreboard_pkg:
  - ASCII code constants (digit base, letters, space).
  - Field width 16, cell width 8, glyph height 16.
  - Ball/strike/out limits.
- Sub-module scoreboard_state: event priority, counters, BCD run counters, half/inning/game_over, frame snapshot.
- scoreboard_ctrl keeps the address generation and render pipeline.

Test Plan:
- Reset, then pixel (TX, TY+5) with video_on → rom_addr = {7'h48, 4'h5} at N+1. text_on at N+3 equals bit 7 of ROM row 'H'/5 (= 1).
- Four ev_ball pulses → balls 1, 2, 3, then 0 with strikes 0. Three ev_strike from strikes 0 → outs = 1, balls = strikes = 0.
- Six outs from top 1st → half 0→1→0, inning = 2. ev_run during top → away BCD increments, home unchanged.
- Runs 8'h99 plus ev_run → 8'h00. Runs 8'h09 plus ev_run → 8'h10.
- Bottom of 9th with outs = 2, then ev_out → game_over = 1. ev_ball/ev_run then ignored. ev_new_game → inning 1, runs 00, game_over 0.
- ev_run coincident with frame_start → rendered digit shows old value until the next frame_start. Pixel outside the field, or video_on = 0, → text_on = 0 three cycles later.
